data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Parametrised word-organised data memory with built-in load/store unit for the MIPS pipeline MEM stage.
//  Takes byte/half/word loads and stores through a valid/ready request port and returns in-order responses after a fixed latency.
//  Adds sign/zero extension, misalignment and range error reporting, and a sequential clear-after-reset sweep.
//  Emits the standard store trace line.
// PARAMETERS
//  DEPTH          4096          number of 32-bit words; power of 2, >=16
//  RD_LAT         1             request-accept to response latency in cycles, 1..4
//  BASE_ADDR      32'h0000_0000 byte address of word 0; word-aligned
//  CLEAR_ON_RESET 1             1: sweep-clear array after Rst; 0: contents undefined, ready right after reset
//  TRACE          1             1: $display every performed store
// PORTS
//  Clk        in   1   clock, all state on rising edge
//  Rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept this cycle
//  req_we     in   1   1 store, 0 load
//  req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed in   1   loads only: 1 sign-extend, 0 zero-extend
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  req_pc     in   32  PC of issuing instruction, trace only
//  rsp_valid  out  1   response valid, one-cycle pulse per accepted request
//  rsp_data   out  32  extended load data; 0 for stores and errors
//  rsp_err    out  1   request was misaligned, illegal size, or out of range
// BEHAVIOUR
//  - Reset: Rst sync, active-high, clock Clk. While Rst=1: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, all pipeline valids cleared; in-flight requests are dropped with no response.
//  - FSM: CLEAR -> RUN. Rst forces CLEAR with clr_idx=0 (or RUN directly if CLEAR_ON_RESET=0).
//  - CLEAR: writes word clr_idx to 0 each cycle after Rst falls; req_ready=0. After writing DEPTH-1, go to RUN.
//    req_ready goes to 1 exactly DEPTH cycles after the first cycle with Rst=0.
//    Rst asserted in CLEAR restarts the sweep at 0.
//  - RUN: req_ready=1 every cycle. No response backpressure; the consumer always accepts.
//  - Accept = req_valid & req_ready. At most one request per cycle.
//  - Offset off = req_addr - BASE_ADDR, 32-bit wraparound.
//    Word index = off[log2(DEPTH)+1:2]; lane = off[1:0].
//  - Error conditions, any of:
//    - size 11;
//    - half with lane[0]=1;
//    - word with lane != 0;
//    - off >= 4*DEPTH (covers addr below BASE via wrap).
//    An errored store writes nothing; an errored load returns 0. rsp_err=1 in both cases.
//  - Store, on the accept edge, lanes written:
//    - byte: lane;
//    - half: lane 0 -> [15:0], lane 2 -> [31:16];
//    - word: all.
//    Other bytes are preserved.
//  - Trace (TRACE=1): one $display("%d@%h: *%h <= %h", $time, req_pc, word-aligned req_addr, merged 32-bit word after write) per performed store.
//  - Load reads the array at the accept edge.
//    A store accepted at edge N is visible to a load accepted at edge N+1 or later; no stale read.
//  - Load extraction: select the lane, then sign/zero-extend to 32 per req_signed. Word loads ignore req_signed.
//  - Latency: the response for a request accepted at edge N is registered so rsp_valid=1 for the cycle after edge N+RD_LAT-1.
//    RD_LAT=1 means the cycle right after accept. Stage shift register depth RD_LAT-1.
//  - Responses stay in strict accept order; back-to-back accepts give back-to-back responses.
//  - rsp_data/rsp_err hold their last value when rsp_valid=0. Only rsp_valid is pulse-qualified.
// TESTING
//  - Rst 1 cycle, CLEAR_ON_RESET=1, DEPTH=16 -> req_ready=0 for 16 cycles, then 1; lw at each word returns 0.
//  - sw 0x12345678 @0x0, then lb signed @0x3, lbu @0x0, lh @0x2 back-to-back -> rsp_data 0x00000012, 0x00000078, 0x00001234, one rsp_valid per cycle.
//  - sb 0x80 @0x5 over word 0 at 0x4 -> trace shows *00000004 <= 00008000; lb @0x5 -> 0xFFFFFF80; lbu -> 0x00000080.
//  - sh @0x1, lw @0x2, size 11, lw @4*DEPTH -> four rsp_err=1, rsp_data=0; memory unchanged; no trace line.
//  - RD_LAT=3: 3 loads on consecutive cycles -> rsp_valid 3 cycles after each accept, in order; sw then lw same word next cycle -> new data.
//  - Rst mid-stream with 2 loads in flight -> no rsp_valid after Rst; sweep restarts; req_ready returns after DEPTH cycles.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with a built-in load/store unit for the pipeline MEM stage.
// Byte/half/word accesses, fixed-latency in-order responses, error reporting, clear sweep after reset.
//
//   state   | meaning
//   S_CLEAR | zeroing word clr_idx_q each cycle, requests blocked
//   S_RUN   | accepting one request per cycle
module data_mem_lsu #(
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned RD_LAT         = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          TRACE          = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clearing;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic [1:0]    lane;
  logic [AW-1:0] widx;
  logic          err;
  logic          accept;
  logic          store_do;
  logic [31:0]   rd_word;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   merged;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_data;

  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic          v_q [RD_LAT];
  logic [31:0]   d_q [RD_LAT];
  logic          e_q [RD_LAT];

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (&clr_idx_q) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clearing    = (state_q == S_CLEAR) && !Rst;
    req_ready_o = (state_q == S_RUN) && !Rst;
  end

  assign off      = req_addr_i - BASE_ADDR;
  assign lane     = off[1:0];
  assign widx     = off[AW+1:2];
  assign err      = (req_size_i == 2'b11)
                  | ((req_size_i == 2'b01) & lane[0])
                  | ((req_size_i == 2'b10) & (|lane))
                  | (|off[31:AW+2]);
  assign accept   = req_valid_i & req_ready_o;
  assign store_do = accept & req_we_i & ~err;
  assign rd_word  = mem[widx];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be[lane]  = 1'b1;
        wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = be[b] ? wdata_rep[8*b +: 8] : rd_word[8*b +: 8];
  end

  always_comb begin
    byte_v = rd_word[{lane, 3'b000} +: 8];
    half_v = rd_word[{lane[1], 4'b0000} +: 16];
    case (req_size_i)
      2'b00:   ld_data = {{24{req_signed_i & byte_v[7]}}, byte_v};
      2'b01:   ld_data = {{16{req_signed_i & half_v[15]}}, half_v};
      default: ld_data = rd_word;
    endcase
    if (err || req_we_i) ld_data = '0;
  end

  // The sweep and stores never overlap: requests are blocked while clearing.
  assign mem_we    = clearing | store_do;
  assign mem_widx  = clearing ? clr_idx_q : widx;
  assign mem_wdata = clearing ? 32'h0 : merged;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Response pipeline; data/err only move with a valid so the output holds between pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
        e_q[i] <= 1'b0;
      end
    end else begin
      v_q[0] <= accept;
      if (accept) begin
        d_q[0] <= ld_data;
        e_q[0] <= err;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          d_q[i] <= d_q[i-1];
          e_q[i] <= e_q[i-1];
        end
      end
    end
  end

  assign rsp_valid_o = v_q[RD_LAT-1] & ~Rst;
  assign rsp_data_o  = Rst ? 32'h0 : d_q[RD_LAT-1];
  assign rsp_err_o   = e_q[RD_LAT-1] & ~Rst;

`ifndef SYNTHESIS
  always @(posedge Clk) begin
    if (TRACE && store_do)
      $display("%d@%h: *%h <= %h", $time, req_pc_i, {req_addr_i[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: two instances (latency 1 and 3) share one stimulus stream and
// are compared every cycle against a byte-lane memory model and an accept-order queue.
module tb_data_mem_lsu;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;

  logic        rdy1, v1, e1, rdy3, v3, e3;
  logic [31:0] d1, d3;

  always #5 Clk = ~Clk;

  data_mem_lsu #(.DEPTH(DEPTH), .RD_LAT(1), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1), .TRACE(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .req_valid_i(req_valid), .req_ready_o(rdy1), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_pc_i(req_pc), .rsp_valid_o(v1), .rsp_data_o(d1), .rsp_err_o(e1));

  data_mem_lsu #(.DEPTH(DEPTH), .RD_LAT(3), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1), .TRACE(1'b0)) dut3 (
    .Clk(Clk), .Rst(Rst), .req_valid_i(req_valid), .req_ready_o(rdy3), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_pc_i(req_pc), .rsp_valid_o(v3), .rsp_data_o(d3), .rsp_err_o(e3));

  typedef struct {
    int unsigned acc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        hist[$];
  int unsigned head [2] = '{0, 0};
  logic [31:0] last_d [2] = '{0, 0};
  logic        last_e [2] = '{0, 0};
  logic [31:0] mem_m [DEPTH];
  int unsigned cyc = 0;
  int unsigned since_rst = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge Clk) cyc++;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: memory as bytes addressed by offset, extension by plain arithmetic.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data, output logic err);
    logic [31:0] off, word, mask, v;
    int unsigned w, lane;
    off  = addr - BASE;
    err  = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) ||
           (size == 2'd2 && off % 4 != 0) || (off >= 4 * DEPTH);
    data = 32'h0;
    if (err) return;
    w    = off / 4;
    lane = off % 4;
    word = mem_m[w];
    if (we) begin
      if (size == 2'd0)      mask = 32'h0000_00FF << (8 * lane);
      else if (size == 2'd1) mask = 32'h0000_FFFF << (8 * lane);
      else                   mask = 32'hFFFF_FFFF;
      mem_m[w] = (word & ~mask) | ((wdata << (8 * lane)) & mask);
    end else begin
      v = word >> (8 * lane);
      case (size)
        2'd0:    data = (sgn && v[7])  ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
        2'd1:    data = (sgn && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
        default: data = word;
      endcase
    end
  endfunction

  task automatic mon(input int k, input int lat, input logic rdy, input logic v,
                     input logic [31:0] d, input logic e);
    string p;
    p = (k == 0) ? "L1" : "L3";
    chk_eq({p, " ready"}, rdy, (!Rst && since_rst >= DEPTH));
    if (Rst) begin
      head[k]   = hist.size();
      last_d[k] = 32'h0;
      last_e[k] = 1'b0;
      chk_eq({p, " valid in reset"}, v, 0);
      chk_eq({p, " data in reset"}, d, 0);
    end else if (head[k] < hist.size() && hist[head[k]].acc + lat == cyc) begin
      chk_eq({p, " valid"}, v, 1);
      chk_eq({p, " data"}, d, hist[head[k]].data);
      chk_eq({p, " err"}, e, hist[head[k]].err);
      last_d[k] = hist[head[k]].data;
      last_e[k] = hist[head[k]].err;
      head[k]++;
    end else begin
      chk_eq({p, " idle valid"}, v, 0);
      chk_eq({p, " hold data"}, d, last_d[k]);
      chk_eq({p, " hold err"}, e, last_e[k]);
    end
  endtask

  always @(negedge Clk) begin
    mon(0, 1, rdy1, v1, d1, e1);
    mon(1, 3, rdy3, v3, d3, e3);
    if (Rst) since_rst = 0;
    else if (since_rst < DEPTH) since_rst++;
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t x;
    model(we, size, sgn, addr, wdata, x.data, x.err);
    x.acc = cyc;
    hist.push_back(x);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = $urandom;
    @(posedge Clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      req_we   = 1'($urandom);
      req_addr = $urandom;
      @(posedge Clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    req_valid = 1'b0;
    repeat (n) begin @(posedge Clk); #1; end
    Rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    repeat (DEPTH) begin @(posedge Clk); #1; end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    #1;
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);

    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678);
    issue(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);

    issue(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_0080);
    issue(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);

    issue(1'b1, 2'd1, 1'b0, 32'h1, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    idle(3);

    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hA5C3_0F96);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_8001);
    issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) idle(1);
      else begin
        sz = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
        a  = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(4 * DEPTH - 1));
        if ($urandom_range(3) != 0) a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
        issue(1'($urandom), sz, 1'($urandom), a, $urandom);
      end
    end

    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    idle(5);
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
